// File: rtl/weight_fifo_ctrl.sv
// Weight FIFO sequencer: per channel flush, load N_OF_PIXELS weights, then replay them N_LOOPS times.
// Optional stall counter on o_stall_cnt is built only when WCTRL_PERF_CNT_EN is defined.
module weight_fifo_ctrl #(
  parameter int BIT_WIDTH     = 8,
  parameter int NO_COL_KERNEL = 5,
  parameter int N_OF_PIXELS   = NO_COL_KERNEL * NO_COL_KERNEL,
  parameter int N_CHANNELS    = 4,
  parameter int N_LOOPS       = 3,
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [ADDR_WIDTH-1:0]         i_base_addr,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  input  logic                          i_mem_rd_valid,
  input  logic [BIT_WIDTH-1:0]          i_mem_rd_data,
  output logic                          o_fifo_wr_en,
  output logic [BIT_WIDTH-1:0]          o_fifo_data,
  output logic                          o_fifo_rd_en,
  output logic                          o_fifo_loop_back,
  output logic                          o_fifo_flush,
  input  logic                          i_fifo_full,
  input  logic                          i_fifo_empty,
  input  logic                          i_fifo_flush_fin,
  input  logic                          i_col_done,
  input  logic                          i_core_ready,
  output logic [$clog2(N_CHANNELS):0]   o_channel_idx,
  output logic [$clog2(N_LOOPS):0]      o_loop_idx,
  output logic [7:0]                    o_col_cnt,
  output logic [31:0]                   o_stall_cnt
);

  localparam int CNT_W = $clog2(N_OF_PIXELS + 1);
  localparam int CH_W  = $clog2(N_CHANNELS) + 1;
  localparam int LP_W  = $clog2(N_LOOPS) + 1;
  localparam logic [CNT_W-1:0] NPIX      = CNT_W'(N_OF_PIXELS);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CHANNELS - 1);
  localparam logic [LP_W-1:0]  LOOP_LAST = LP_W'(N_LOOPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_WAIT_FLUSH, S_LOAD, S_READ, S_LOOP_CHK, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [LP_W-1:0]         loop_q, loop_d;
  logic [7:0]              col_cnt_q, col_cnt_d;
  logic                    col_done_q, col_done_d;
  logic                    err_q, err_d;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    issue_cnt_d      = issue_cnt_q;
    wr_cnt_d         = wr_cnt_q;
    rd_cnt_d         = rd_cnt_q;
    ch_d             = ch_q;
    loop_d           = loop_q;
    col_cnt_d        = col_cnt_q;
    col_done_d       = i_col_done;
    err_d            = err_q;
    o_done           = 1'b0;
    o_mem_rd_en      = 1'b0;
    o_fifo_wr_en     = 1'b0;
    o_fifo_rd_en     = 1'b0;
    o_fifo_loop_back = 1'b0;
    o_fifo_flush     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d    = i_base_addr;
          ch_d      = '0;
          loop_d    = '0;
          col_cnt_d = '0;
          state_d   = S_FLUSH;
        end
      end
      S_FLUSH: begin
        o_fifo_flush = 1'b1;
        state_d      = S_WAIT_FLUSH;
      end
      S_WAIT_FLUSH: begin
        if (i_fifo_flush_fin) begin
          issue_cnt_d = '0;
          wr_cnt_d    = '0;
          rd_cnt_d    = '0;
          col_cnt_d   = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        // Read data returns one cycle after the request and goes straight into the FIFO.
        o_fifo_wr_en = i_mem_rd_valid;
        if (issue_cnt_q < NPIX && !i_fifo_full && !err_q) begin
          o_mem_rd_en = 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
          addr_d      = addr_q + 1'b1;
        end
        if (i_mem_rd_valid)
          wr_cnt_d = wr_cnt_q + 1'b1;
        // A full FIFO before the channel is loaded is a protocol violation; park here.
        if (i_fifo_full && wr_cnt_q < NPIX)
          err_d = 1'b1;
        if (wr_cnt_q == NPIX && !err_q)
          state_d = S_READ;
      end
      S_READ: begin
        o_fifo_rd_en = i_core_ready && !i_fifo_empty && (rd_cnt_q < NPIX);
        if (o_fifo_rd_en)
          rd_cnt_d = rd_cnt_q + 1'b1;
        if (i_col_done && !col_done_q)
          col_cnt_d = col_cnt_q + 1'b1;
        if (rd_cnt_q == NPIX)
          state_d = S_LOOP_CHK;
      end
      S_LOOP_CHK: begin
        if (loop_q < LOOP_LAST) begin
          o_fifo_loop_back = 1'b1;
          loop_d           = loop_q + 1'b1;
          rd_cnt_d         = '0;
          col_cnt_d        = '0;
          state_d          = S_READ;
        end else begin
          ch_d    = ch_q + 1'b1;
          loop_d  = '0;
          state_d = (ch_q == CH_LAST) ? S_DONE : S_FLUSH;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      ch_q        <= '0;
      loop_q      <= '0;
      col_cnt_q   <= '0;
      col_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      ch_q        <= ch_d;
      loop_q      <= loop_d;
      col_cnt_q   <= col_cnt_d;
      col_done_q  <= col_done_d;
      err_q       <= err_d;
    end
  end

  assign o_busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_mem_addr    = addr_q;
  assign o_fifo_data   = o_fifo_wr_en ? i_mem_rd_data : '0;
  assign o_channel_idx = ch_q;
  assign o_loop_idx    = loop_q;
  assign o_col_cnt     = col_cnt_q;

`ifdef WCTRL_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && i_start)
      stall_d = '0;
    else if (state_q == S_READ && rd_cnt_q < NPIX && (!i_core_ready || i_fifo_empty)
             && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign o_stall_cnt = stall_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
